// File: rtl/prescaled_updown_counter_pkg.sv
// Shared definitions for the prescaled counter family: counting modes and
// the width helper used to size prescaler registers.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // Ceiling log2, never below 1 so a divide-by-1 prescaler still has a register.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/prescaled_updown_counter_if.sv
// Control and status bundle of the prescaled up/down counter.
// The master side drives the run/step/load controls and observes the count.
interface prescaled_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic             CE;
    logic [1:0]       MODE;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             DIR;
    logic             TICK;
    logic             CEO;

    modport master (
        output EN, CE, MODE, LOAD, D,
        input  Q, DIR, TICK, CEO
    );

    modport slave (
        input  EN, CE, MODE, LOAD, D,
        output Q, DIR, TICK, CEO
    );
endinterface

// File: rtl/prescaled_updown_counter_ce_prescaler.sv
// Programmable clock-enable generator: one single-cycle TICK every DIV
// enabled cycles. Generic replacement for fixed-ratio enable dividers.
module ce_prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic C,
    input  logic CLR_N,
    input  logic EN,
    input  logic SCLR,
    output logic TICK
);

    localparam int PW = clog2_min1(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] p_r;
    logic          at_last;

    assign at_last = (p_r == LAST);

    // Phase counter: SCLR restarts the period, EN=0 freezes it in place.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            p_r <= '0;
        end else if (SCLR) begin
            p_r <= '0;
        end else if (EN) begin
            p_r <= at_last ? '0 : p_r + PW'(1);
        end
    end

    // Gated by CLR_N so no tick can leak out while the block is held in reset.
    assign TICK = CLR_N & EN & at_last;

endmodule

// File: rtl/prescaled_updown_counter.sv
// Prescaled WIDTH-bit counter with up, down, bounce and hold modes,
// synchronous clamped load and a cascade enable for the next stage.
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int WIDTH = 4,
    parameter int MAX   = 2**WIDTH - 1
) (
    input  logic                       C,
    input  logic                       CLR_N,
    prescaled_updown_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic             tick;
    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             dir_r;
    logic             dir_nxt;
    mode_e            mode;

    assign mode = mode_e'(bus.MODE);

    ce_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .C     (C),
        .CLR_N (CLR_N),
        .EN    (bus.EN),
        .SCLR  (bus.LOAD),
        .TICK  (tick)
    );

    assign step = tick & bus.CE;

    // Terminal-count decode: the state from which the next step rolls over or turns.
    always_comb begin
        boundary = 1'b0;
        case (mode)
            MODE_UP:     boundary = (q_r == MAX_Q);
            MODE_DOWN:   boundary = (q_r == '0);
            MODE_BOUNCE: boundary = (dir_r & (q_r == MAX_Q)) | (~dir_r & (q_r == '0));
            default:     boundary = 1'b0;
        endcase
    end

    // Next count/direction: LOAD wins over a coincident step, which is dropped.
    always_comb begin
        q_nxt   = q_r;
        dir_nxt = dir_r;
        if (bus.LOAD) begin
            q_nxt   = (int'(bus.D) > MAX) ? MAX_Q : bus.D;
            dir_nxt = (mode != MODE_DOWN);
        end else if (step) begin
            case (mode)
                MODE_UP: begin
                    dir_nxt = 1'b1;
                    // >= also folds an out-of-range count back to 0.
                    q_nxt   = (q_r >= MAX_Q) ? '0 : q_r + ONE;
                end
                MODE_DOWN: begin
                    dir_nxt = 1'b0;
                    q_nxt   = (q_r == '0) ? MAX_Q : q_r - ONE;
                end
                MODE_BOUNCE: begin
                    if (dir_r) begin
                        if (q_r >= MAX_Q) begin
                            q_nxt   = MAX_M1;
                            dir_nxt = 1'b0;
                        end else begin
                            q_nxt = q_r + ONE;
                        end
                    end else begin
                        if (q_r == '0) begin
                            q_nxt   = ONE;
                            dir_nxt = 1'b1;
                        end else begin
                            q_nxt = q_r - ONE;
                        end
                    end
                end
                default: begin
                    q_nxt   = q_r;
                    dir_nxt = dir_r;
                end
            endcase
        end
    end

    // Count and direction registers; reset leaves the counter at 0 heading up.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            q_r   <= '0;
            dir_r <= 1'b1;
        end else begin
            q_r   <= q_nxt;
            dir_r <= dir_nxt;
        end
    end

    assign bus.Q    = q_r;
    assign bus.DIR  = dir_r;
    assign bus.TICK = tick;
    assign bus.CEO  = step & ~bus.LOAD & boundary;

endmodule
